// File: rtl/store_buffer_mq_if.sv
// store_buffer_mq_if: MEM-side, ROB-side, cache-side and load-forwarding signals of the store buffer
// Modports: master = pipeline/cache side (drives alloc, commit, flush, drain_ready, load query),
//           slave  = store buffer (drives drain, forwarding result, occupancy).
interface store_buffer_mq_if #(
  parameter int N = 8,
  parameter int WORD_SIZE = 32,
  parameter int WIDTH = 32,
  parameter int ROB_ENTRY_WIDTH = 6,
  parameter int SIZE_WRITE_WIDTH = 2
);
  localparam int BL = WORD_SIZE / 8;
  localparam int CW = $clog2(N) + 1;
  logic                        alloc_valid;
  logic [WIDTH-1:0]            alloc_addr;
  logic [WORD_SIZE-1:0]        alloc_data;
  logic [SIZE_WRITE_WIDTH-1:0] alloc_size;
  logic [ROB_ENTRY_WIDTH-1:0]  alloc_rob_id;
  logic                        alloc_exc;
  logic                        commit_valid;
  logic [ROB_ENTRY_WIDTH-1:0]  commit_rob_id;
  logic                        flush;
  logic                        drain_valid;
  logic [WIDTH-1:0]            drain_addr;
  logic [WORD_SIZE-1:0]        drain_data;
  logic [BL-1:0]               drain_mask;
  logic                        drain_ready;
  logic [WIDTH-1:0]            ld_addr;
  logic [SIZE_WRITE_WIDTH-1:0] ld_size;
  logic                        fwd_hit;
  logic                        fwd_full;
  logic [WORD_SIZE-1:0]        fwd_data;
  logic                        full;
  logic                        empty;
  logic [CW-1:0]               count;
  modport master (
    output alloc_valid, alloc_addr, alloc_data, alloc_size, alloc_rob_id, alloc_exc,
    output commit_valid, commit_rob_id, flush, drain_ready, ld_addr, ld_size,
    input  drain_valid, drain_addr, drain_data, drain_mask, fwd_hit, fwd_full, fwd_data,
    input  full, empty, count
  );
  modport slave (
    input  alloc_valid, alloc_addr, alloc_data, alloc_size, alloc_rob_id, alloc_exc,
    input  commit_valid, commit_rob_id, flush, drain_ready, ld_addr, ld_size,
    output drain_valid, drain_addr, drain_data, drain_mask, fwd_hit, fwd_full, fwd_data,
    output full, empty, count
  );
endinterface

// File: rtl/store_buffer_mq.sv
// store_buffer_mq: circular store buffer holding speculative stores until commit, draining in order to the D-cache
// Ports: clk, rst (sync, active-high), sb (store_buffer_mq_if.slave): alloc_*, commit_*, flush,
//        drain_* valid/ready to cache, ld_addr/ld_size -> fwd_hit/fwd_full/fwd_data, full/empty/count.
// Option: STORE_BUFFER_COALESCE_EN merges two committed head entries to the same word into one drain.
module store_buffer_mq #(
  parameter int N = 8,
  parameter int WORD_SIZE = 32,
  parameter int WIDTH = 32,
  parameter int ROB_ENTRY_WIDTH = 6,
  parameter int SIZE_WRITE_WIDTH = 2
) (
  input logic clk,
  input logic rst,
  store_buffer_mq_if.slave sb
);
  localparam int BL = WORD_SIZE / 8;
  localparam int OFF = $clog2(BL);
  localparam int PW = $clog2(N);
  localparam int CW = PW + 1;
  localparam logic [SIZE_WRITE_WIDTH-1:0] SZ_B = 0;
  localparam logic [SIZE_WRITE_WIDTH-1:0] SZ_H = 1;

  function automatic logic [OFF-1:0] lo_lane(input logic [WIDTH-1:0] a, input logic [SIZE_WRITE_WIDTH-1:0] s);
    return (s == SZ_B) ? a[OFF-1:0] : (s == SZ_H) ? {a[OFF-1:1], 1'b0} : '0;
  endfunction

  function automatic logic [BL-1:0] lane_mask(input logic [WIDTH-1:0] a, input logic [SIZE_WRITE_WIDTH-1:0] s);
    logic [BL-1:0] base;
    base = (s == SZ_B) ? BL'(1) : (s == SZ_H) ? BL'(3) : '1;
    return base << lo_lane(a, s);
  endfunction

  function automatic logic [WORD_SIZE-1:0] bytes(input logic [BL-1:0] mk);
    logic [WORD_SIZE-1:0] r;
    r = '0;
    for (int l = 0; l < BL; l++) r[8*l +: 8] = {8{mk[l]}};
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] word_addr(input logic [WIDTH-1:0] a);
    return {a[WIDTH-1:OFF], {OFF{1'b0}}};
  endfunction

  logic [N-1:0]               v, c;
  logic [WIDTH-1:0]           wa  [N];
  logic [BL-1:0]              m   [N];
  logic [WORD_SIZE-1:0]       d   [N];
  logic [ROB_ENTRY_WIDTH-1:0] rob [N];
  logic [PW-1:0]              head, tail, h1, ix_c, ix_f, cm_idx;
  logic [CW-1:0]              cnt, cnt_n, ncom, npop;
  logic                       full_r, empty_r, cm_hit, co, dv, pop, do_alloc;
  logic [BL-1:0]              amask, req, cov, got, dmask;
  logic [WORD_SIZE-1:0]       fw, ddata;

  // Committed entries form a prefix from head, so scanning from head finds the oldest match.
  always_comb begin
    cm_hit = 1'b0;
    cm_idx = '0;
    ncom = '0;
    ix_c = '0;
    for (int k = 0; k < N; k++) begin
      ix_c = head + PW'(k);
      ncom = ncom + CW'(v[ix_c] & c[ix_c]);
      if (!cm_hit && sb.commit_valid && v[ix_c] && !c[ix_c] && rob[ix_c] == sb.commit_rob_id) begin
        cm_hit = 1'b1;
        cm_idx = ix_c;
      end
    end
  end

  // Oldest-to-youngest scan so later (younger) entries overwrite each byte lane.
  always_comb begin
    fw = '0;
    cov = '0;
    ix_f = '0;
    for (int k = 0; k < N; k++) begin
      ix_f = head + PW'(k);
      if (v[ix_f] && wa[ix_f] == word_addr(sb.ld_addr))
        for (int l = 0; l < BL; l++)
          if (m[ix_f][l]) begin
            fw[8*l +: 8] = d[ix_f][8*l +: 8];
            cov[l] = 1'b1;
          end
    end
  end

  assign req = lane_mask(sb.ld_addr, sb.ld_size);
  assign got = req & cov;
  assign sb.fwd_hit = |got;
  assign sb.fwd_full = got == req;
  assign sb.fwd_data = (fw & bytes(got)) >> {lo_lane(sb.ld_addr, sb.ld_size), 3'b000};

  assign h1 = head + PW'(1);
  assign dv = v[head] & c[head];
`ifdef STORE_BUFFER_COALESCE_EN
  assign co = dv & v[h1] & c[h1] & (wa[head] == wa[h1]);
  assign dmask = co ? (m[head] | m[h1]) : m[head];
  assign ddata = co ? ((d[h1] & bytes(m[h1])) | (d[head] & ~bytes(m[h1]))) : d[head];
`else
  assign co = 1'b0;
  assign dmask = m[head];
  assign ddata = d[head];
`endif

  assign sb.drain_valid = dv;
  assign sb.drain_addr = wa[head];
  assign sb.drain_mask = dmask;
  assign sb.drain_data = ddata;
  assign sb.full = full_r;
  assign sb.empty = empty_r;
  assign sb.count = cnt;

  assign pop = dv & sb.drain_ready;
  assign npop = !pop ? '0 : co ? CW'(2) : CW'(1);
  assign do_alloc = sb.alloc_valid & ~full_r & ~sb.alloc_exc & ~sb.flush;
  assign amask = lane_mask(sb.alloc_addr, sb.alloc_size);
  assign cnt_n = sb.flush ? ncom + CW'(cm_hit) - npop : cnt + CW'(do_alloc) - npop;

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      full_r <= 1'b0;
      empty_r <= 1'b1;
      v <= '0;
      c <= '0;
    end else begin
      cnt <= cnt_n;
      full_r <= cnt_n == CW'(N);
      empty_r <= cnt_n == '0;
      head <= head + npop[PW-1:0];
      if (cm_hit) c[cm_idx] <= 1'b1;
      if (sb.flush) begin
        for (int i = 0; i < N; i++)
          if (!c[i] && !(cm_hit && cm_idx == PW'(i))) v[i] <= 1'b0;
        tail <= head + ncom[PW-1:0] + PW'(cm_hit);
      end else if (do_alloc) begin
        v[tail] <= 1'b1;
        c[tail] <= 1'b0;
        wa[tail] <= word_addr(sb.alloc_addr);
        m[tail] <= amask;
        d[tail] <= (sb.alloc_data << {lo_lane(sb.alloc_addr, sb.alloc_size), 3'b000}) & bytes(amask);
        rob[tail] <= sb.alloc_rob_id;
        tail <= tail + PW'(1);
      end
      if (pop) begin
        v[head] <= 1'b0;
        c[head] <= 1'b0;
      end
      if (pop && co) begin
        v[h1] <= 1'b0;
        c[h1] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_store_buffer_mq.sv
// tb_store_buffer_mq: directed self-checking bench for store_buffer_mq (N=8, 32-bit words)
module tb_store_buffer_mq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_buffer_mq_if sb ();
  store_buffer_mq dut (.clk(clk), .rst(rst), .sb(sb));

  int total = 0;
  int bad = 0;

  task automatic st(input logic [31:0] a, input logic [31:0] dd, input logic [1:0] s, input logic [5:0] r);
    sb.alloc_valid = 1'b1;
    sb.alloc_addr = a;
    sb.alloc_data = dd;
    sb.alloc_size = s;
    sb.alloc_rob_id = r;
    @(negedge clk);
    sb.alloc_valid = 1'b0;
  endtask

  task automatic cm(input logic [5:0] r);
    sb.commit_valid = 1'b1;
    sb.commit_rob_id = r;
    @(negedge clk);
    sb.commit_valid = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] s);
    sb.ld_addr = a;
    sb.ld_size = s;
    #1;
  endtask

  task automatic pop1;
    sb.drain_ready = 1'b1;
    @(negedge clk);
    sb.drain_ready = 1'b0;
  endtask

  task automatic do_flush;
    sb.flush = 1'b1;
    @(negedge clk);
    sb.flush = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ld(32'h0, 2'd2);
    total++; if (sb.empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0h want=1", sb.empty); end
    total++; if (sb.full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0h want=0", sb.full); end
    total++; if (sb.count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0h want=0", sb.count); end
    total++; if (sb.drain_valid !== 1'b0) begin bad++; $display("FAIL rst_dvalid got=%0h want=0", sb.drain_valid); end
    total++; if ({sb.fwd_hit, sb.fwd_full, sb.fwd_data} !== 34'h0) begin bad++; $display("FAIL rst_fwd got=%0h/%0h/%0h want=0/0/0", sb.fwd_hit, sb.fwd_full, sb.fwd_data); end
  endtask

  task automatic test_drain;
    st(32'h100, 32'hAABBCCDD, 2'd2, 6'd3);
    total++; if (sb.count !== 4'd1 || sb.drain_valid !== 1'b0) begin bad++; $display("FAIL t2_alloc got=cnt %0h dv %0h want=cnt 1 dv 0", sb.count, sb.drain_valid); end
    cm(6'd3);
    total++; if (sb.drain_valid !== 1'b1) begin bad++; $display("FAIL t2_dvalid got=%0h want=1", sb.drain_valid); end
    total++; if (sb.drain_addr !== 32'h100 || sb.drain_mask !== 4'hF) begin bad++; $display("FAIL t2_addr_mask got=%0h/%0h want=100/f", sb.drain_addr, sb.drain_mask); end
    total++; if (sb.drain_data !== 32'hAABBCCDD) begin bad++; $display("FAIL t2_data got=%0h want=aabbccdd", sb.drain_data); end
    pop1();
    total++; if (sb.empty !== 1'b1 || sb.count !== 4'd0 || sb.drain_valid !== 1'b0) begin bad++; $display("FAIL t2_pop got=e %0h c %0h dv %0h want=e 1 c 0 dv 0", sb.empty, sb.count, sb.drain_valid); end
  endtask

  task automatic test_forward;
    st(32'h200, 32'h11223344, 2'd2, 6'd5);
    st(32'h202, 32'h00000099, 2'd0, 6'd6);
    ld(32'h200, 2'd2);
    total++; if (sb.fwd_full !== 1'b1 || sb.fwd_data !== 32'h11993344) begin bad++; $display("FAIL t3_lw got=%0h/%0h want=1/11993344", sb.fwd_full, sb.fwd_data); end
    ld(32'h203, 2'd0);
    total++; if (sb.fwd_hit !== 1'b1 || sb.fwd_data !== 32'h11) begin bad++; $display("FAIL t3_lb got=%0h/%0h want=1/11", sb.fwd_hit, sb.fwd_data); end
    ld(32'h202, 2'd1);
    total++; if (sb.fwd_data !== 32'h1199) begin bad++; $display("FAIL t3_lh got=%0h want=1199", sb.fwd_data); end
    ld(32'h204, 2'd2);
    total++; if (sb.fwd_hit !== 1'b0 || sb.fwd_data !== 32'h0) begin bad++; $display("FAIL t3_miss got=%0h/%0h want=0/0", sb.fwd_hit, sb.fwd_data); end
    st(32'h202, 32'hFFFFFF77, 2'd0, 6'd7);
    ld(32'h200, 2'd2);
    total++; if (sb.fwd_data !== 32'h11773344) begin bad++; $display("FAIL t3_young got=%0h want=11773344", sb.fwd_data); end
    sb.alloc_valid = 1'b1;
    sb.alloc_addr = 32'h208;
    sb.alloc_data = 32'hCAFEF00D;
    sb.alloc_size = 2'd2;
    sb.alloc_rob_id = 6'd8;
    ld(32'h208, 2'd2);
    total++; if (sb.fwd_hit !== 1'b0) begin bad++; $display("FAIL t3_same_cycle got=%0h want=0", sb.fwd_hit); end
    @(negedge clk);
    sb.alloc_valid = 1'b0;
    ld(32'h208, 2'd2);
    total++; if (sb.fwd_full !== 1'b1 || sb.fwd_data !== 32'hCAFEF00D) begin bad++; $display("FAIL t3_next got=%0h/%0h want=1/cafef00d", sb.fwd_full, sb.fwd_data); end
    sb.alloc_exc = 1'b1;
    st(32'h20C, 32'h5, 2'd2, 6'd9);
    sb.alloc_exc = 1'b0;
    total++; if (sb.count !== 4'd4) begin bad++; $display("FAIL t3_exc got=%0h want=4", sb.count); end
    do_flush();
    total++; if (sb.count !== 4'd0 || sb.empty !== 1'b1) begin bad++; $display("FAIL t3_flush got=%0h/%0h want=0/1", sb.count, sb.empty); end
  endtask

  task automatic test_full;
    st(32'h300, 32'hDEADBEEF, 2'd1, 6'd1);
    ld(32'h300, 2'd2);
    total++; if (sb.fwd_hit !== 1'b1 || sb.fwd_full !== 1'b0 || sb.fwd_data !== 32'h0000BEEF) begin bad++; $display("FAIL t4_partial got=%0h/%0h/%0h want=1/0/beef", sb.fwd_hit, sb.fwd_full, sb.fwd_data); end
    for (int i = 2; i <= 8; i++) st(32'h310 + 32'(4 * i), 32'(i), 2'd2, 6'(i));
    total++; if (sb.count !== 4'd8 || sb.full !== 1'b1) begin bad++; $display("FAIL t4_full got=%0h/%0h want=8/1", sb.count, sb.full); end
    st(32'h3F0, 32'h9, 2'd2, 6'd9);
    total++; if (sb.count !== 4'd8) begin bad++; $display("FAIL t4_extra got=%0h want=8", sb.count); end
    cm(6'd1);
    total++; if (sb.drain_valid !== 1'b1 || sb.drain_mask !== 4'h3 || sb.drain_data !== 32'h0000BEEF) begin bad++; $display("FAIL t4_drain got=%0h/%0h/%0h want=1/3/beef", sb.drain_valid, sb.drain_mask, sb.drain_data); end
    sb.drain_ready = 1'b1;
    st(32'h3F4, 32'hA, 2'd2, 6'd10);
    sb.drain_ready = 1'b0;
    total++; if (sb.count !== 4'd7 || sb.full !== 1'b0) begin bad++; $display("FAIL t4_pop_full got=%0h/%0h want=7/0", sb.count, sb.full); end
    st(32'h3F8, 32'hB, 2'd2, 6'd11);
    ld(32'h3F4, 2'd2);
    total++; if (sb.count !== 4'd8 || sb.full !== 1'b1 || sb.fwd_hit !== 1'b0) begin bad++; $display("FAIL t4_refill got=%0h/%0h/%0h want=8/1/0", sb.count, sb.full, sb.fwd_hit); end
    do_flush();
  endtask

  task automatic test_back_to_back;
    st(32'h700, 32'h1, 2'd2, 6'd1);
    cm(6'd1);
    sb.drain_ready = 1'b1;
    st(32'h704, 32'h2, 2'd2, 6'd2);
    sb.drain_ready = 1'b0;
    total++; if (sb.count !== 4'd1 || sb.empty !== 1'b0 || sb.drain_valid !== 1'b0) begin bad++; $display("FAIL b2b_count got=%0h/%0h/%0h want=1/0/0", sb.count, sb.empty, sb.drain_valid); end
    ld(32'h700, 2'd2);
    total++; if (sb.fwd_hit !== 1'b0) begin bad++; $display("FAIL b2b_old got=%0h want=0", sb.fwd_hit); end
    ld(32'h704, 2'd2);
    total++; if (sb.fwd_data !== 32'h2) begin bad++; $display("FAIL b2b_new got=%0h want=2", sb.fwd_data); end
    do_flush();
  endtask

  task automatic test_flush;
    for (int i = 1; i <= 4; i++) st(32'h5FC + 32'(4 * i), 32'hA0 + 32'(i), 2'd2, 6'(i));
    cm(6'd1);
    cm(6'd2);
    do_flush();
    total++; if (sb.count !== 4'd2) begin bad++; $display("FAIL t5_count got=%0h want=2", sb.count); end
    total++; if (sb.drain_valid !== 1'b1 || sb.drain_addr !== 32'h600 || sb.drain_data !== 32'hA1) begin bad++; $display("FAIL t5_first got=%0h/%0h/%0h want=1/600/a1", sb.drain_valid, sb.drain_addr, sb.drain_data); end
    repeat (2) @(negedge clk);
    total++; if (sb.drain_valid !== 1'b1 || sb.drain_addr !== 32'h600 || sb.drain_data !== 32'hA1 || sb.count !== 4'd2) begin bad++; $display("FAIL t5_hold got=%0h/%0h/%0h want=1/600/a1", sb.drain_valid, sb.drain_addr, sb.drain_data); end
    pop1();
    total++; if (sb.drain_addr !== 32'h604 || sb.drain_data !== 32'hA2 || sb.count !== 4'd1) begin bad++; $display("FAIL t5_second got=%0h/%0h/%0h want=604/a2/1", sb.drain_addr, sb.drain_data, sb.count); end
    ld(32'h608, 2'd2);
    total++; if (sb.fwd_hit !== 1'b0) begin bad++; $display("FAIL t5_squashed got=%0h want=0", sb.fwd_hit); end
    pop1();
    total++; if (sb.empty !== 1'b1) begin bad++; $display("FAIL t5_empty got=%0h want=1", sb.empty); end
    st(32'h610, 32'h7, 2'd2, 6'd7);
    st(32'h614, 32'h8, 2'd2, 6'd8);
    sb.commit_valid = 1'b1;
    sb.commit_rob_id = 6'd7;
    sb.alloc_valid = 1'b1;
    sb.alloc_addr = 32'h618;
    sb.alloc_rob_id = 6'd9;
    do_flush();
    sb.commit_valid = 1'b0;
    sb.alloc_valid = 1'b0;
    total++; if (sb.count !== 4'd1 || sb.drain_valid !== 1'b1 || sb.drain_addr !== 32'h610) begin bad++; $display("FAIL t5_commit_flush got=%0h/%0h/%0h want=1/1/610", sb.count, sb.drain_valid, sb.drain_addr); end
    st(32'h61C, 32'hC, 2'd2, 6'd12);
    sb.drain_ready = 1'b1;
    do_flush();
    sb.drain_ready = 1'b0;
    total++; if (sb.count !== 4'd0 || sb.empty !== 1'b1 || sb.drain_valid !== 1'b0) begin bad++; $display("FAIL t5_pop_flush got=%0h/%0h/%0h want=0/1/0", sb.count, sb.empty, sb.drain_valid); end
  endtask

  task automatic test_coalesce;
    st(32'h400, 32'h11, 2'd0, 6'd1);
    st(32'h401, 32'h22, 2'd0, 6'd2);
    cm(6'd1);
    cm(6'd2);
    total++; if (sb.count !== 4'd2) begin bad++; $display("FAIL t6_count got=%0h want=2", sb.count); end
`ifdef STORE_BUFFER_COALESCE_EN
    total++; if (sb.drain_mask !== 4'h3 || sb.drain_data !== 32'h00002211) begin bad++; $display("FAIL t6_merge got=%0h/%0h want=3/2211", sb.drain_mask, sb.drain_data); end
    pop1();
    total++; if (sb.count !== 4'd0) begin bad++; $display("FAIL t6_pop got=%0h want=0", sb.count); end
`else
    total++; if (sb.drain_mask !== 4'h1 || sb.drain_data !== 32'h00000011) begin bad++; $display("FAIL t6_first got=%0h/%0h want=1/11", sb.drain_mask, sb.drain_data); end
    pop1();
    total++; if (sb.count !== 4'd1 || sb.drain_mask !== 4'h2 || sb.drain_data !== 32'h00002200) begin bad++; $display("FAIL t6_second got=%0h/%0h/%0h want=1/2/2200", sb.count, sb.drain_mask, sb.drain_data); end
    pop1();
    total++; if (sb.count !== 4'd0) begin bad++; $display("FAIL t6_pop got=%0h want=0", sb.count); end
`endif
  endtask

  task automatic test_reset_mid;
    st(32'h800, 32'h5, 2'd2, 6'd1);
    cm(6'd1);
    sb.drain_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (sb.drain_valid !== 1'b0 || sb.empty !== 1'b1 || sb.count !== 4'd0) begin bad++; $display("FAIL rst_mid got=%0h/%0h/%0h want=0/1/0", sb.drain_valid, sb.empty, sb.count); end
  endtask

  initial begin
    sb.alloc_valid = 1'b0;
    sb.alloc_addr = '0;
    sb.alloc_data = '0;
    sb.alloc_size = '0;
    sb.alloc_rob_id = '0;
    sb.alloc_exc = 1'b0;
    sb.commit_valid = 1'b0;
    sb.commit_rob_id = '0;
    sb.flush = 1'b0;
    sb.drain_ready = 1'b0;
    sb.ld_addr = '0;
    sb.ld_size = '0;
    test_reset();
    test_drain();
    test_forward();
    test_full();
    test_back_to_back();
    test_flush();
    test_coalesce();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
